// File: rtl/lcd_text_writer.sv
// lcd_text_writer: 2-line frame buffer streamed to the LCD controller byte handshake.
// Define LCD_DIRTY_LINE_EN to send only lines written since they were last sent.
module lcd_text_writer #(
  parameter int         CHARS_PER_LINE = 16,
  parameter logic [7:0] LINE0_CMD      = 8'h80,
  parameter logic [7:0] LINE1_CMD      = 8'hC0,
  parameter int         ACK_TIMEOUT    = 64
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                wr_en,
  input  logic [$clog2(2*CHARS_PER_LINE)-1:0] wr_addr,
  input  logic [7:0]                          wr_data,
  input  logic                                refresh,
  input  logic                                busy_flag,
  output logic                                data_ready,
  output logic [7:0]                          d_out,
  output logic                                rs_out,
  output logic                                frame_busy,
  output logic                                frame_done,
  output logic                                ack_error
);
  localparam int N  = 2*CHARS_PER_LINE;
  localparam int AW = $clog2(N);
  localparam int IW = $clog2(N+2);
  localparam int CW = $clog2(ACK_TIMEOUT+1);
  localparam logic [IW-1:0] LAST0 = IW'(CHARS_PER_LINE);
  localparam logic [IW-1:0] CMD1  = IW'(CHARS_PER_LINE+1);
  localparam logic [IW-1:0] LAST1 = IW'(N+1);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_buf [N];
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_d;
  logic          r_rs, r_pending, r_done, r_err;
  logic          w_load, w_take, w_done, w_abort, w_last, w_rs;
  logic [1:0]    w_dirty;
  logic [AW-1:0] w_bidx;
  logic [7:0]    w_byte;

`ifdef LCD_DIRTY_LINE_EN
  logic [1:0] r_dirty, w_set, w_clr;
  assign w_set = !wr_en ? 2'b00 : (wr_addr >= AW'(CHARS_PER_LINE)) ? 2'b10 : 2'b01;
  assign w_clr = !(r_state == REQ && busy_flag) ? 2'b00 :
                 (r_idx == '0) ? 2'b01 : (r_idx == CMD1) ? 2'b10 : 2'b00;
  // a write marks its line; acknowledging that line's cursor command clears it (write wins)
  always_ff @(posedge clk or posedge reset)
    if (reset) r_dirty <= 2'b11;
    else       r_dirty <= (r_dirty & ~w_clr) | w_set;
  assign w_dirty = r_dirty;
`else
  assign w_dirty = 2'b11;
`endif

  assign w_last = (r_idx == LAST1) || (r_idx == LAST0 && !w_dirty[1]);

  // sequencer: next state, next sequence index and handshake events
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    w_take      = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pending && w_dirty == 2'b00) begin
          w_take = 1'b1;
          w_done = 1'b1;
        end else if (r_pending && !busy_flag) begin
          w_take      = 1'b1;
          w_load      = 1'b1;
          w_idx_nxt   = w_dirty[0] ? '0 : CMD1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (busy_flag) w_state_nxt = HOLD;
        else if (r_cnt == CW'(ACK_TIMEOUT-1)) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (!busy_flag && w_last) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else if (!busy_flag) begin
          w_load      = 1'b1;
          w_idx_nxt   = r_idx + IW'(1);
          w_state_nxt = REQ;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_bidx = AW'(w_idx_nxt - ((w_idx_nxt > LAST0) ? IW'(2) : IW'(1)));
  assign w_byte = (w_idx_nxt == '0) ? LINE0_CMD : (w_idx_nxt == CMD1) ? LINE1_CMD : r_buf[w_bidx];
  assign w_rs   = (w_idx_nxt != '0) && (w_idx_nxt != CMD1);

  // state register; reset aborts any frame at once
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;

  // byte latch, timeout counter, pending request and one-cycle status pulses
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_idx     <= '0;
      r_cnt     <= '0;
      r_d       <= 8'h00;
      r_rs      <= 1'b0;
      r_pending <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_idx     <= w_idx_nxt;
      r_cnt     <= w_load ? '0 : r_cnt + CW'(1);
      if (w_load) begin
        r_d  <= w_byte;
        r_rs <= w_rs;
      end
      r_pending <= refresh | (r_pending & !w_take & !w_abort);
      r_done    <= w_done;
      r_err     <= w_abort;
    end

  // frame buffer, cleared to spaces
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < N; i++) r_buf[i] <= 8'h20;
    else if (wr_en) r_buf[wr_addr] <= wr_data;

  assign data_ready = (r_state == REQ);
  assign frame_busy = (r_state != IDLE);
  assign d_out      = r_d;
  assign rs_out     = r_rs;
  assign frame_done = r_done;
  assign ack_error  = r_err;
endmodule
